// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED scan controller.
// Mode and FSM state types plus the default prescaler width.
package led_ctrl_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN_UP = 2'b01,
        S_RUN_DN = 2'b10
    } state_e;

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Control and display bundle of the LED scan controller.
// master drives control, slave (the controller) drives the scan outputs.
interface led_scan_ctrl_if
    import led_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             en;
    mode_e            mode;
    logic [CNT_W-1:0] div;
    logic [2:0]       sel;
    logic [7:0]       led;
    logic             step;
    logic             busy;

    modport master (
        output en, mode, div,
        input  sel, led, step, busy
    );

    modport slave (
        input  en, mode, div,
        output sel, led, step, busy
    );

endinterface

// File: rtl/led_scan_ctrl_tick_gen.sv
// Prescaler: ticks when count >= div, then restarts from zero.
// The >= compare avoids wrapping when div drops below count.
module tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             tick
);

    logic [CNT_W-1:0] count;

    assign tick = !clr && (count >= div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// LED scan controller: FSM-driven position with one-cold LED drive.
// Position, LED pattern and step pulse update on the edge after a tick.
module led_scan_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    led_scan_ctrl_if.slave  bus
);

    state_e     state;
    state_e     state_nxt;
    logic       tick;
    logic       clr;
    logic       upd;
    logic       pp_dn;
    logic [2:0] sel_nxt;

    assign clr = (state == S_IDLE) || !bus.en;

    tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .div   (bus.div),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = bus.sel;
        upd       = 1'b0;
        pp_dn     = 1'b0;
        if (state == S_IDLE) begin
            if (bus.en) begin
                state_nxt = (bus.mode == MODE_DOWN)
                          ? S_RUN_DN : S_RUN_UP;
            end
        end else if (!bus.en) begin
            state_nxt = S_IDLE;
        end else if (tick) begin
            unique case (1'b1)
                bus.mode == MODE_UP: begin
                    state_nxt = S_RUN_UP;
                    sel_nxt   = bus.sel + 3'd1;
                    upd       = 1'b1;
                end
                bus.mode == MODE_DOWN: begin
                    state_nxt = S_RUN_DN;
                    sel_nxt   = bus.sel - 3'd1;
                    upd       = 1'b1;
                end
                bus.mode == MODE_PINGPONG: begin
                    // bounce off an end position, else keep direction
                    pp_dn = (state == S_RUN_UP)
                          ? (bus.sel == 3'd7)
                          : (bus.sel != 3'd0);
                    sel_nxt = pp_dn ? bus.sel - 3'd1
                                    : bus.sel + 3'd1;
                    upd     = 1'b1;
                    if (sel_nxt == 3'd7) begin
                        state_nxt = S_RUN_DN;
                    end else if (sel_nxt == 3'd0) begin
                        state_nxt = S_RUN_UP;
                    end else begin
                        state_nxt = pp_dn ? S_RUN_DN : S_RUN_UP;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_comb begin
        bus.busy = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sel  <= 3'd0;
            bus.led  <= 8'hFE;
            bus.step <= 1'b0;
        end else begin
            bus.step <= upd;
            if (upd) begin
                bus.sel <= sel_nxt;
                bus.led <= ~(8'd1 << sel_nxt);
            end
        end
    end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, prescaler counter and divide-value width.
REQ-002 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port en  input  1  1 = scanning runs; 0 = scanning paused.
REQ-005 Port mode  input  2  00 UP, 01 DOWN, 10 PINGPONG, 11 HOLD.
REQ-006 Port div  input  CNT_W  prescaler terminal value; position advances once every div+1 cycles.
REQ-007 Port sel  output  3  current scan position (decoder select), registered.
REQ-008 Port led  output  8  active-low one-cold drive, led[i]=0 only for i==sel, registered.
REQ-009 Port step  output  1  one-cycle pulse coincident with every sel update.
REQ-010 Port busy  output  1  1 while FSM is not IDLE.

Function
REQ-011 Prescaler: count increments each cycle in RUN_UP/RUN_DN; tick asserted when count >= div; count returns to 0 on tick.
REQ-012 div = 0 shall produce a tick every cycle.
REQ-013 div changed mid-count to a value below the current count: tick on the next cycle (>= compare), no wrap through 2^CNT_W.
REQ-014 FSM states: IDLE, RUN_UP, RUN_DN.
REQ-015 IDLE -> RUN_UP when en=1 and mode is UP, PINGPONG or HOLD; IDLE -> RUN_DN when en=1 and mode is DOWN.
REQ-016 Any RUN state -> IDLE when en=0; count cleared to 0; sel and led held.
REQ-017 On tick in UP: sel <= sel+1, 7 wraps to 0.
REQ-018 On tick in DOWN: sel <= sel-1, 0 wraps to 7.
REQ-019 On tick in PINGPONG: RUN_UP increments, RUN_DN decrements; sel 7 reached in RUN_UP -> next state RUN_DN; sel 0 reached in RUN_DN -> RUN_UP; end positions shown for exactly one step period (sequence 0..7,6..0,1..).
REQ-020 PINGPONG entered from UP/DOWN at sel=7 while in RUN_UP: next tick moves to 6 and state to RUN_DN; at sel=0 in RUN_DN: next tick to 1, state RUN_UP.
REQ-021 UP mode shall force state RUN_UP and DOWN mode RUN_DN at the next tick, before computing the new sel.
REQ-022 HOLD: prescaler runs, ticks produce no sel change and no step pulse.
REQ-023 Mode changes take effect only at a tick; sel never changes outside a tick.
REQ-024 led = ~(8'b1 << sel) at all times, updated on the same edge as sel; latency tick-to-sel/led/step = 1 cycle.
REQ-025 step = 1 exactly in cycles where sel changed in the previous edge's update, else 0.
REQ-026 en rising: first tick after div+1 cycles of RUN, not immediately.

Reset
REQ-027 rst_n=0 shall asynchronously force: state IDLE, count 0, sel 0, led 8'b1111_1110, step 0, busy 0.
REQ-028 Reset deassertion mid-scan shall restart from sel 0, no residual step pulse.
REQ-029 Reset release is synchronised externally; block uses no internal synchroniser.

Structure
REQ-030 Shared package led_ctrl_pkg holds mode encodings (MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_HOLD), FSM state encodings, default CNT_W.
REQ-031 One sub-module tick_gen (CNT_W parameter; clk, rst_n, clr, div in; tick out) implements the prescaler.
REQ-032 No other sub-modules; led decode is inline in the registered output stage.

Verification
REQ-033 Reset: rst_n=0 mid-run -> sel=0, led=8'hFE, step=0, busy=0 immediately without clock.
REQ-034 UP, div=0, en=1 -> sel 0,1,..,7,0 on consecutive cycles after first tick; step high each cycle; led 8'hFE,8'hFD,..,8'h7F,8'hFE.
REQ-035 PINGPONG, div=2 -> sel changes every 3 cycles: 0,1,..,7,6,..,0,1; 7 and 0 each held 3 cycles.
REQ-036 DOWN, div=3, from sel=0 -> next value 7, then 6; step spacing 4 cycles.
REQ-037 en dropped at count=2 with div=5, re-raised -> sel unchanged while paused, first step 6 cycles after en=1.
REQ-038 div lowered from 100 to 3 while count=50 -> tick next cycle, then every 4 cycles; HOLD mode -> no step, sel constant over 20 ticks.
